// File: rtl/ram_fifo_pkg.sv
// Shared constants, FSM state type and byte-parity helper for the 8x72 RAM FIFO controller.
package ram_fifo_pkg;
    localparam int DATA_W = 72;
    localparam int ADDR_W = 3;
    localparam int DEPTH  = 1 << ADDR_W;

    typedef enum logic [1:0] {OUT_EMPTY, FETCH, HOLD} state_t;

    // Bit i is the XOR of byte i, so byte plus parity bit always holds an even number of ones.
    function automatic logic [7:0] byte_parity(input logic [63:0] d);
        logic [7:0] p;
        for (int i = 0; i < 8; i++) begin
            p[i] = ^d[8*i +: 8];
        end
        return p;
    endfunction
endpackage

// File: rtl/ram_fifo_ctrl_8x72_ptr.sv
// Write/read pointers and RAM occupancy count for the 8x72 RAM FIFO controller.
module ram_fifo_ctrl_8x72_ptr #(
    parameter int ADDR_W = 3,
    parameter int DEPTH  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_push,
    input  logic              i_rd_issue,
    output logic [ADDR_W-1:0] o_wr_ptr,
    output logic [ADDR_W-1:0] o_rd_ptr,
    output logic [ADDR_W:0]   o_count,
    output logic              o_full,
    output logic              o_count_zero
);
    import ram_fifo_pkg::*;

    localparam logic [ADDR_W:0]   FULL_C  = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   CNT_ONE = 1;
    localparam logic [ADDR_W-1:0] PTR_ONE = 1;

    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W:0]   r_count;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push)     r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (i_rd_issue) r_rd_ptr <= r_rd_ptr + PTR_ONE;
            case ({i_push, i_rd_issue})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_wr_ptr     = r_wr_ptr;
    assign o_rd_ptr     = r_rd_ptr;
    assign o_count      = r_count;
    assign o_full       = (r_count == FULL_C);
    assign o_count_zero = (r_count == '0);
endmodule

// File: rtl/ram_fifo_ctrl_8x72.sv
// Valid/ready FIFO controller in front of an external single-port 8x72 DFF RAM.
// Optional per-byte parity generation/check is compiled in with RAM_FIFO_PARITY_EN.
//
// state     | meaning
// OUT_EMPTY | output register empty; read the RAM as soon as it holds a word
// FETCH     | read in flight; RAM data is captured into the output register at the edge
// HOLD      | output register valid, waiting for the consumer
module ram_fifo_ctrl_8x72 #(
    parameter int DATA_W = ram_fifo_pkg::DATA_W,
    parameter int ADDR_W = ram_fifo_pkg::ADDR_W,
    parameter int DEPTH  = ram_fifo_pkg::DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              empty,
    output logic              par_err,
    output logic              ram_wr_n,
    output logic [ADDR_W-1:0] ram_address,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);
    import ram_fifo_pkg::*;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_m_valid;
    logic [DATA_W-1:0] r_m_data;
    logic [ADDR_W-1:0] w_wr_ptr;
    logic [ADDR_W-1:0] w_rd_ptr;
    logic [ADDR_W:0]   w_count;
    logic              w_full;
    logic              w_count_zero;
    logic              w_rd_issue;
    logic              w_push;
    logic [DATA_W-1:0] w_wdata;

    ram_fifo_ctrl_8x72_ptr #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_ptr (
        .clk          (clk),
        .rst          (rst),
        .i_push       (w_push),
        .i_rd_issue   (w_rd_issue),
        .o_wr_ptr     (w_wr_ptr),
        .o_rd_ptr     (w_rd_ptr),
        .o_count      (w_count),
        .o_full       (w_full),
        .o_count_zero (w_count_zero)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_rd_issue  = 1'b0;
        if (!rst) begin
            case (r_state)
                OUT_EMPTY: begin
                    if (!w_count_zero) begin
                        w_rd_issue  = 1'b1;
                        w_state_nxt = FETCH;
                    end
                end
                FETCH: w_state_nxt = HOLD;
                HOLD: begin
                    if (m_ready) begin
                        if (!w_count_zero) begin
                            w_rd_issue  = 1'b1;
                            w_state_nxt = FETCH;
                        end else begin
                            w_state_nxt = OUT_EMPTY;
                        end
                    end
                end
                default: w_state_nxt = OUT_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= OUT_EMPTY;
            r_m_valid <= 1'b0;
            r_m_data  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == FETCH) begin
                r_m_valid <= 1'b1;
                r_m_data  <= ram_rdata;
            end else if (r_state == HOLD && m_ready) begin
                r_m_valid <= 1'b0;
            end
        end
    end

`ifdef RAM_FIFO_PARITY_EN
    logic r_par_err;

    assign w_wdata = {byte_parity(s_data[63:0]), s_data[63:0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_par_err <= 1'b0;
        end else begin
            r_par_err <= (r_state == FETCH) &&
                         (byte_parity(ram_rdata[63:0]) != ram_rdata[71:64]);
        end
    end

    assign par_err = r_par_err;
`else
    assign w_wdata = s_data;
    assign par_err = 1'b0;
`endif

    // A read issue owns the RAM port, so producers stall for that one cycle.
    assign s_ready     = !w_full && !w_rd_issue;
    assign w_push      = s_valid && s_ready && !rst;
    assign ram_wr_n    = !w_push;
    assign ram_address = w_push ? w_wr_ptr : w_rd_ptr;
    assign ram_wdata   = w_push ? w_wdata : '0;

    assign m_valid = r_m_valid;
    assign m_data  = r_m_data;
    assign count   = w_count;
    assign full    = w_full;
    assign empty   = w_count_zero && !r_m_valid;
endmodule

// File: tb/tb_ram_fifo_ctrl_8x72.sv
// Self-checking bench for ram_fifo_ctrl_8x72: behavioural RAM, queue scoreboard, directed + random steps.
module tb_ram_fifo_ctrl_8x72;
    import ram_fifo_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [71:0] s_data = '0;
    logic        m_valid;
    logic        m_ready = 1'b0;
    logic [71:0] m_data;
    logic [3:0]  count;
    logic        full;
    logic        empty;
    logic        par_err;
    logic        ram_wr_n;
    logic [2:0]  ram_address;
    logic [71:0] ram_wdata;
    logic [71:0] ram_rdata;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ram_fifo_ctrl_8x72 dut (
        .clk(clk), .rst(rst),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .count(count), .full(full), .empty(empty), .par_err(par_err),
        .ram_wr_n(ram_wr_n), .ram_address(ram_address),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    // Behavioural RAM: write at the edge, registered read data one clock later.
    logic [71:0] mem [8];
    logic [71:0] rdata_q = '0;
    logic [71:0] corrupt = '0;
    initial for (int i = 0; i < 8; i++) mem[i] = '0;
    always @(posedge clk) begin
        if (!ram_wr_n) mem[ram_address] <= ram_wdata;
        else           rdata_q <= mem[ram_address];
    end
    assign ram_rdata = rdata_q ^ corrupt;

    task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [71:0] exp_word(input logic [71:0] d);
`ifdef RAM_FIFO_PARITY_EN
        return {byte_parity(d[63:0]), d[63:0]};
`else
        return d;
`endif
    endfunction

    function automatic logic [71:0] rnd72();
        logic [95:0] t;
        t = {$urandom(), $urandom(), $urandom()};
        return t[71:0];
    endfunction

    // Scoreboard: accepted words in order, sequential write address, in-order delivery.
    logic [71:0] sb_q[$];
    logic [2:0]  exp_wa = '0;
    bit          sb_en = 1'b1;
    int          pops = 0;
    always @(negedge clk) begin
        if (rst) begin
            sb_q.delete();
            exp_wa = '0;
        end else begin
            if (m_valid && m_ready) begin
                pops++;
                if (sb_en) begin
                    chk("sb_pop_nonempty", 72'(sb_q.size() != 0), 72'(1));
                    if (sb_q.size() != 0) chk("sb_m_data", m_data, sb_q.pop_front());
                end
            end
            if (s_valid && s_ready) begin
                chk("wr_n_on_push", 72'(ram_wr_n), 72'(0));
                chk("wr_address", 72'(ram_address), 72'(exp_wa));
                chk("wr_data", ram_wdata, exp_word(s_data));
                exp_wa = exp_wa + 3'd1;
                if (sb_en) sb_q.push_back(exp_word(s_data));
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic push_word(input logic [71:0] w);
        bit ok = 1'b0;
        s_valid = 1'b1;
        s_data  = w;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            ok = s_ready;
            @(posedge clk); #1;
            if (ok) break;
        end
        s_valid = 1'b0;
        chk("push_accept", 72'(ok), 72'(1));
    endtask

    task automatic idle_check(input string p);
        @(negedge clk);
        chk({p, "_m_valid"}, 72'(m_valid), 72'(0));
        chk({p, "_empty"}, 72'(empty), 72'(1));
        chk({p, "_count"}, 72'(count), 72'(0));
        chk({p, "_full"}, 72'(full), 72'(0));
        chk({p, "_ram_wr_n"}, 72'(ram_wr_n), 72'(1));
        chk({p, "_ram_address"}, 72'(ram_address), 72'(0));
        chk({p, "_m_data"}, m_data, 72'(0));
        chk({p, "_par_err"}, 72'(par_err), 72'(0));
        chk({p, "_s_ready"}, 72'(s_ready), 72'(1));
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int last, n, sent;
        bit done;
        logic [71:0] cur, held, w6;

        // 1: reset and idle
        cyc(2);
        rst = 1'b0;
        cyc(5);
        idle_check("reset");

        // 2: fill to full; the word in the output register is not counted
        for (int w = 1; w <= 9; w++) push_word(72'(w));
        @(negedge clk);
        chk("fill_count", 72'(count), 72'(8));
        chk("fill_full", 72'(full), 72'(1));
        chk("fill_s_ready", 72'(s_ready), 72'(0));
        chk("fill_m_data", m_data, exp_word(72'(1)));
        @(posedge clk); #1;
        s_valid = 1'b1;
        s_data  = 72'(10);
        repeat (3) begin
            @(negedge clk);
            chk("full_no_write", 72'(ram_wr_n), 72'(1));
            chk("full_s_ready", 72'(s_ready), 72'(0));
            @(posedge clk); #1;
        end
        s_valid = 1'b0;

        // 3: drain at one word every two cycles
        m_ready = 1'b1;
        last = -1;
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (m_valid) begin
                if (last >= 0) chk("drain_gap", 72'(i - last), 72'(2));
                last = i;
                n++;
            end
            @(posedge clk); #1;
            if (n == 9) break;
        end
        chk("drain_words", 72'(n), 72'(9));
        m_ready = 1'b0;
        @(negedge clk);
        chk("drain_empty", 72'(empty), 72'(1));
        chk("drain_count", 72'(count), 72'(0));
        @(posedge clk); #1;

        // 4: single-word latency; read address wrapped to 1 after nine reads
        push_word(72'hA5);
        @(negedge clk);
        chk("lat_read_wr_n", 72'(ram_wr_n), 72'(1));
        chk("lat_read_addr", 72'(ram_address), 72'(1));
        chk("lat_c1_m_valid", 72'(m_valid), 72'(0));
        @(posedge clk); #1;
        @(negedge clk);
        chk("lat_c2_m_valid", 72'(m_valid), 72'(0));
        @(posedge clk); #1;
        @(negedge clk);
        chk("lat_c3_m_valid", 72'(m_valid), 72'(1));
        chk("lat_c3_m_data", m_data, exp_word(72'hA5));
        held = m_data;
        @(posedge clk); #1;
        repeat (4) begin
            @(negedge clk);
            chk("hold_m_valid", 72'(m_valid), 72'(1));
            chk("hold_m_data", m_data, held);
            @(posedge clk); #1;
        end
        m_ready = 1'b1;
        cyc(1);
        m_ready = 1'b0;
        @(negedge clk);
        chk("single_empty", 72'(empty), 72'(1));
        @(posedge clk); #1;

        // 5: read issue blocks the producer, FETCH cycle accepts
        for (int i = 0; i < 4; i++) push_word(rnd72());
        s_valid = 1'b1;
        s_data  = rnd72();
        m_ready = 1'b1;
        @(negedge clk);
        chk("ilv_count", 72'(count), 72'(3));
        chk("ilv_issue_s_ready", 72'(s_ready), 72'(0));
        chk("ilv_issue_wr_n", 72'(ram_wr_n), 72'(1));
        @(posedge clk); #1;
        m_ready = 1'b0;
        @(negedge clk);
        chk("ilv_fetch_s_ready", 72'(s_ready), 72'(1));
        chk("ilv_fetch_m_valid", 72'(m_valid), 72'(0));
        @(posedge clk); #1;
        s_valid = 1'b0;

        sent = 0;
        done = 1'b0;
        cur = rnd72();
        for (int c = 0; c < 1000; c++) begin
            s_valid = (sent < 20);
            s_data  = cur;
            m_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (s_valid && s_ready) begin
                sent++;
                cur = rnd72();
            end
            @(posedge clk); #1;
            if (sent == 20 && sb_q.size() == 0) begin
                done = 1'b1;
                break;
            end
        end
        s_valid = 1'b0;
        m_ready = 1'b0;
        chk("rand_complete", 72'(done), 72'(1));
        cyc(2);
        @(negedge clk);
        chk("rand_empty", 72'(empty), 72'(1));
        @(posedge clk); #1;

        // reset mid-stream
        for (int i = 0; i < 3; i++) push_word(rnd72());
        s_valid = 1'b1;
        s_data  = rnd72();
        rst = 1'b1;
        @(negedge clk);
        chk("rst_no_write", 72'(ram_wr_n), 72'(1));
        @(posedge clk); #1;
        rst = 1'b0;
        s_valid = 1'b0;
        cyc(5);
        idle_check("midrst");

        // 6: corrupt bit 3 of the read data during the fetch
        sb_en = 1'b0;
        w6 = 72'h00_0102_0304_0506_0708;
        corrupt = 72'h8;
        push_word(w6);
        @(negedge clk);
        chk("par_c1", 72'(par_err), 72'(0));
        @(posedge clk); #1;
        @(negedge clk);
        chk("par_c2", 72'(par_err), 72'(0));
        @(posedge clk); #1;
        @(negedge clk);
        chk("par_m_valid", 72'(m_valid), 72'(1));
        chk("par_m_data", m_data, exp_word(w6) ^ 72'h8);
`ifdef RAM_FIFO_PARITY_EN
        chk("par_pulse", 72'(par_err), 72'(1));
`else
        chk("par_pulse", 72'(par_err), 72'(0));
`endif
        @(posedge clk); #1;
        @(negedge clk);
        chk("par_after", 72'(par_err), 72'(0));
        @(posedge clk); #1;
        corrupt = '0;
        m_ready = 1'b1;
        cyc(1);
        m_ready = 1'b0;
        sb_en = 1'b1;
        @(negedge clk);
        chk("final_empty", 72'(empty), 72'(1));
        chk("final_par_err", 72'(par_err), 72'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
